shift_rows: RTL and testbench



---
 rtl/aes_pkg.sv | 15 +
 rtl/shift_rows_if.sv | 27 ++
 rtl/shift_rows_perm.sv | 23 ++
 rtl/shift_rows.sv | 36 +++
 tb/tb_shift_rows.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and helpers for the round datapath.
// The state is a 4x4 byte matrix stored column-major; byte 0 is bits 0..7.
package aes_pkg;

  typedef logic [0:127] state_t;
  typedef logic [7:0]   byte_t;

  localparam int unsigned AES_NB          = 4;
  localparam int unsigned AES_STATE_BYTES = 16;

  function automatic int unsigned byte_idx(input int unsigned r, input int unsigned c);
    return r + AES_NB * c;
  endfunction

endpackage

// File: rtl/shift_rows_if.sv
// Streaming bus for the ShiftRows stage: a state in, a permuted state out.
interface shift_rows_if;
  import aes_pkg::*;

  logic   valid_i;
  logic   inv_i;
  state_t message;
  state_t crypte;
  logic   valid_o;

  modport master (
    output valid_i,
    output inv_i,
    output message,
    input  crypte,
    input  valid_o
  );

  modport slave (
    input  valid_i,
    input  inv_i,
    input  message,
    output crypte,
    output valid_o
  );

endinterface

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation.
// Row r rotates left by r (forward) or right by r (inverse).
module shift_rows_perm
  import aes_pkg::*;
(
  input  state_t state_in,
  input  logic   inv,
  output state_t state_out
);

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      localparam int unsigned CFwd = (c + r) % 4;
      localparam int unsigned CInv = (c - r + 4) % 4;
      localparam int unsigned Dst  = byte_idx(r, c);
      localparam int unsigned SFwd = byte_idx(r, CFwd);
      localparam int unsigned SInv = byte_idx(r, CInv);

      assign state_out[8*Dst +: 8] = inv ? state_in[8*SInv +: 8] : state_in[8*SFwd +: 8];
    end
  end

endmodule

// File: rtl/shift_rows.sv
// ShiftRows stage with one registered output; inv_i selects the decrypt direction.
module shift_rows
  import aes_pkg::*;
(
  input logic         clk,
  input logic         rst,
  shift_rows_if.slave bus
);

  state_t perm_out;
  state_t crypte_q;
  logic   valid_q;

  shift_rows_perm u_perm (
    .state_in  (bus.message),
    .inv       (bus.inv_i),
    .state_out (perm_out)
  );

  // Load only on valid so an idle (possibly X) message never reaches the register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crypte_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= bus.valid_i;
      if (bus.valid_i) begin
        crypte_q <= perm_out;
      end
    end
  end

  assign bus.crypte  = crypte_q;
  assign bus.valid_o = valid_q;

endmodule

// File: tb/tb_shift_rows.sv
// Directed and round-trip checks for the registered ShiftRows stage.
module tb_shift_rows;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  shift_rows_if bus ();

  shift_rows dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input state_t got, input state_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  localparam state_t IdxIn   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam state_t IdxFwd  = 128'h00050a0f04090e03080d02070c01060b;
  localparam state_t RepIn   = 128'h0123456789abcdef0123456789abcdef;
  localparam state_t RepFwd  = 128'h01ab45ef8923cd6701ab45ef8923cd67;
  localparam state_t FipsIn  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam state_t FipsFwd = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam state_t Same    = {16{8'h5a}};

  // One transfer: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic xfer(input state_t msg, input logic inv, output state_t res, output logic vo);
    @(negedge clk);
    bus.valid_i = 1'b1;
    bus.inv_i   = inv;
    bus.message = msg;
    @(posedge clk);
    #1;
    res = bus.crypte;
    vo  = bus.valid_o;
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.message = '0;
  endtask

  state_t res, orig, fwd;
  logic   vo;
  state_t s_in  [3];
  logic   s_inv [3];
  state_t s_exp [3];

  initial begin
    bus.valid_i = 1'b0;
    bus.inv_i   = 1'b0;
    bus.message = '0;

    // Reset behaviour, including asynchronous assertion mid-cycle.
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_crypte", bus.crypte, '0);
    check_eq("reset_valid", state_t'(bus.valid_o), '0);
    @(negedge clk);
    rst = 1'b0;
    xfer(IdxIn, 1'b0, res, vo);
    check_eq("pre_reset_load", res, IdxFwd);
    @(negedge clk);
    bus.valid_i = 1'b1;
    bus.message = RepIn;
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_reset_crypte", bus.crypte, '0);
    check_eq("async_reset_valid", state_t'(bus.valid_o), '0);
    @(posedge clk);
    #1;
    check_eq("held_reset_crypte", bus.crypte, '0);
    check_eq("held_reset_valid", state_t'(bus.valid_o), '0);
    @(negedge clk);
    bus.valid_i = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("post_reset_no_valid", state_t'(bus.valid_o), '0);
    check_eq("post_reset_crypte", bus.crypte, '0);

    // Forward vectors.
    xfer(IdxIn, 1'b0, res, vo);
    check_eq("fwd_idx", res, IdxFwd);
    check_eq("fwd_idx_valid", state_t'(vo), state_t'(1'b1));
    @(posedge clk);
    #1;
    check_eq("valid_one_cycle", state_t'(bus.valid_o), '0);
    xfer(RepIn, 1'b0, res, vo);
    check_eq("fwd_rep", res, RepFwd);
    xfer(FipsIn, 1'b0, res, vo);
    check_eq("fwd_fips", res, FipsFwd);

    // Inverse vectors.
    xfer(IdxFwd, 1'b1, res, vo);
    check_eq("inv_idx", res, IdxIn);
    check_eq("inv_idx_valid", state_t'(vo), state_t'(1'b1));
    xfer(FipsFwd, 1'b1, res, vo);
    check_eq("inv_fips", res, FipsIn);

    // Back-to-back stream with alternating direction, then hold.
    s_in[0] = IdxIn;   s_inv[0] = 1'b0; s_exp[0] = IdxFwd;
    s_in[1] = FipsFwd; s_inv[1] = 1'b1; s_exp[1] = FipsIn;
    s_in[2] = RepIn;   s_inv[2] = 1'b0; s_exp[2] = RepFwd;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.valid_i = 1'b1;
      bus.inv_i   = s_inv[i];
      bus.message = s_in[i];
      @(posedge clk);
      #1;
      check_eq($sformatf("stream%0d", i), bus.crypte, s_exp[i]);
      check_eq($sformatf("stream%0d_valid", i), state_t'(bus.valid_o), state_t'(1'b1));
    end
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.inv_i   = 1'b1;
    bus.message = FipsIn;
    @(posedge clk);
    #1;
    check_eq("hold_crypte", bus.crypte, RepFwd);
    check_eq("hold_valid", state_t'(bus.valid_o), '0);

    // Uniform-byte state is a fixed point in both directions.
    xfer(Same, 1'b0, res, vo);
    check_eq("same_fwd", res, Same);
    xfer(Same, 1'b1, res, vo);
    check_eq("same_inv", res, Same);

    // Random round trips: inverse(forward(x)) == x.
    for (int i = 0; i < 1000; i++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      xfer(orig, 1'b0, fwd, vo);
      xfer(fwd, 1'b1, res, vo);
      check_eq($sformatf("roundtrip%0d", i), res, orig);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
